// File: rtl/simple_top_parity_pkg.sv
// Shared widths and injection FSM encoding for the SIMPLE_TOP initiator parity block.
package simple_top_parity_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } inj_state_e;

endpackage

// File: rtl/BOS_SOC_SYNCHSR.sv
// Two-flop synchronizer for quasi-static control levels crossing into clk.
module BOS_SOC_SYNCHSR #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] i_d,
   output logic [DW-1:0] o_q
);

   logic [DW-1:0] r_meta;
   logic [DW-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/simple_top_parity_tx.sv
// Initiator-side parity: generates WADDR/WDATA/RADDR parity, checks RDATA parity.
// Define SIMPLE_TOP_PARITY_TX_ERRCNT_EN to build the saturating ERR_CNT counter.
module simple_top_parity_tx #(
   parameter int ADDR_W = simple_top_parity_pkg::ADDR_W,
   parameter int DATA_W = simple_top_parity_pkg::DATA_W
`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
   ,parameter int CNT_W = simple_top_parity_pkg::CNT_W
`endif
) (
   input  logic              ACLK,
   input  logic              RESETN_ACLK,
   input  logic [ADDR_W-1:0] WADDR_DATA,
   input  logic              WADDR_VALID,
   output logic              WADDR_PARITY,
   input  logic [DATA_W-1:0] WDATA_DATA,
   input  logic              WDATA_VALID,
   output logic              WDATA_PARITY,
   input  logic [ADDR_W-1:0] RADDR_DATA,
   input  logic              RADDR_VALID,
   output logic              RADDR_PARITY,
   input  logic [DATA_W-1:0] RDATA_DATA,
   input  logic              RDATA_VALID,
   input  logic              RDATA_PARITY,
   input  logic              ENERR_RDATA_PARITY,
   input  logic              FIERR_RDATA_PARITY,
   input  logic              ERR_CLR,
   output logic              ERR_RDATA_PARITY,
   output logic              ERR_RDATA_PARITY_B
`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
   ,output logic [CNT_W-1:0] ERR_CNT
`endif
);

   import simple_top_parity_pkg::*;

   logic       r_enerr;
   logic       r_fierr;
   logic       r_mis;
   logic       r_err;
   logic       w_inject;
   logic       w_mis_nxt;
   logic       w_set;
   inj_state_e r_state;
   inj_state_e w_state_nxt;

   // Outgoing parity is purely combinational so it tracks the beat even in reset.
   assign WADDR_PARITY = WADDR_VALID & (^WADDR_DATA);
   assign WDATA_PARITY = WDATA_VALID & (^WDATA_DATA);
   assign RADDR_PARITY = RADDR_VALID & (^RADDR_DATA);

   BOS_SOC_SYNCHSR #(.DW(1)) u_sync_enerr (
      .clk   (ACLK),
      .rst_n (RESETN_ACLK),
      .i_d   (ENERR_RDATA_PARITY),
      .o_q   (r_enerr)
   );

   BOS_SOC_SYNCHSR #(.DW(1)) u_sync_fierr (
      .clk   (ACLK),
      .rst_n (RESETN_ACLK),
      .i_d   (FIERR_RDATA_PARITY),
      .o_q   (r_fierr)
   );

   always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
      if (!RESETN_ACLK) r_state <= IDLE;
      else              r_state <= w_state_nxt;
   end

   // One corrupted beat per injection request; DONE waits for the request to drop.
   always_comb begin
      w_state_nxt = r_state;
      w_inject    = 1'b0;
      case (r_state)
         IDLE:    if (r_fierr) w_state_nxt = ARMED;
         ARMED: begin
            if (RDATA_VALID) begin
               w_inject    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE:    if (!r_fierr) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_mis_nxt = RDATA_VALID & ((^RDATA_DATA) ^ RDATA_PARITY ^ w_inject);
   assign w_set     = r_mis & r_enerr;

   always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
      if (!RESETN_ACLK) begin
         r_mis <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_mis <= w_mis_nxt;
         if (w_set)        r_err <= 1'b1;
         else if (ERR_CLR) r_err <= 1'b0;
      end
   end

   assign ERR_RDATA_PARITY   = r_err;
   assign ERR_RDATA_PARITY_B = ~r_err;

`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Counts every mismatch regardless of enable; a coincident clear keeps the new one.
   always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
      if (!RESETN_ACLK) begin
         r_cnt <= '0;
      end else if (ERR_CLR) begin
         r_cnt <= {{(CNT_W-1){1'b0}}, r_mis};
      end else if (r_mis && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign ERR_CNT = r_cnt;
`endif

endmodule

// File: tb/tb_simple_top_parity_tx.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural model, monitor compares.
module tb_simple_top_parity_tx;

   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int CMAX = 255;

   logic          ACLK;
   logic          RESETN_ACLK;
   logic [AW-1:0] WADDR_DATA;
   logic          WADDR_VALID;
   logic          WADDR_PARITY;
   logic [DW-1:0] WDATA_DATA;
   logic          WDATA_VALID;
   logic          WDATA_PARITY;
   logic [AW-1:0] RADDR_DATA;
   logic          RADDR_VALID;
   logic          RADDR_PARITY;
   logic [DW-1:0] RDATA_DATA;
   logic          RDATA_VALID;
   logic          RDATA_PARITY;
   logic          ENERR_RDATA_PARITY;
   logic          FIERR_RDATA_PARITY;
   logic          ERR_CLR;
   logic          ERR_RDATA_PARITY;
   logic          ERR_RDATA_PARITY_B;
`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
   logic [7:0]    ERR_CNT;
`endif

   simple_top_parity_tx dut (
      .ACLK               (ACLK),
      .RESETN_ACLK        (RESETN_ACLK),
      .WADDR_DATA         (WADDR_DATA),
      .WADDR_VALID        (WADDR_VALID),
      .WADDR_PARITY       (WADDR_PARITY),
      .WDATA_DATA         (WDATA_DATA),
      .WDATA_VALID        (WDATA_VALID),
      .WDATA_PARITY       (WDATA_PARITY),
      .RADDR_DATA         (RADDR_DATA),
      .RADDR_VALID        (RADDR_VALID),
      .RADDR_PARITY       (RADDR_PARITY),
      .RDATA_DATA         (RDATA_DATA),
      .RDATA_VALID        (RDATA_VALID),
      .RDATA_PARITY       (RDATA_PARITY),
      .ENERR_RDATA_PARITY (ENERR_RDATA_PARITY),
      .FIERR_RDATA_PARITY (FIERR_RDATA_PARITY),
      .ERR_CLR            (ERR_CLR),
      .ERR_RDATA_PARITY   (ERR_RDATA_PARITY),
      .ERR_RDATA_PARITY_B (ERR_RDATA_PARITY_B)
`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
      ,.ERR_CNT           (ERR_CNT)
`endif
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   typedef struct {
      bit wa;
      bit wd;
      bit ra;
      bit err;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Stimulus for the next cycle, applied at the falling edge by cyc().
   bit          s_rst = 1'b0;
   bit          s_rand_bus = 1'b1;
   bit [AW-1:0] s_wa, s_ra;
   bit [DW-1:0] s_wd, s_rd;
   bit          s_wav, s_wdv, s_rav;
   bit          s_rv, s_rp;
   bit          s_en, s_fi, s_clr;

   // Reference model state.
   bit m_err, m_mis, m_pend, m_spent;
   int m_cnt;
   bit en_h[$];
   bit fi_h[$];

   function automatic bit odd64(input bit [DW-1:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
      end
   endtask

   task automatic model_clear();
      m_err = 0; m_mis = 0; m_pend = 0; m_spent = 0; m_cnt = 0;
      en_h = '{0, 0};
      fi_h = '{0, 0};
   endtask

   task automatic cyc();
      exp_t e;
      bit ren, rfi, inj, nmis;
      @(negedge ACLK);
      if (s_rand_bus) begin
         s_wa = $urandom; s_ra = $urandom; s_wd = {$urandom, $urandom};
         s_wav = $urandom_range(0, 1); s_wdv = $urandom_range(0, 1); s_rav = $urandom_range(0, 1);
      end
      RESETN_ACLK = s_rst;
      WADDR_DATA = s_wa; WADDR_VALID = s_wav;
      WDATA_DATA = s_wd; WDATA_VALID = s_wdv;
      RADDR_DATA = s_ra; RADDR_VALID = s_rav;
      RDATA_DATA = s_rd; RDATA_VALID = s_rv; RDATA_PARITY = s_rp;
      ENERR_RDATA_PARITY = s_en; FIERR_RDATA_PARITY = s_fi; ERR_CLR = s_clr;
      if (!s_rst) model_clear();
      e.wa  = s_wav && ($countones(s_wa) % 2 == 1);
      e.wd  = s_wdv && odd64(s_wd);
      e.ra  = s_rav && ($countones(s_ra) % 2 == 1);
      e.err = m_err;
      e.cnt = m_cnt;
      sb.push_back(e);
      if (s_rst) begin
         ren = en_h[0];
         rfi = fi_h[0];
         inj  = m_pend && s_rv;
         nmis = s_rv && (odd64(s_rd) ^ s_rp ^ inj);
         if (m_mis && ren) m_err = 1;
         else if (s_clr)   m_err = 0;
         if (s_clr)                      m_cnt = m_mis ? 1 : 0;
         else if (m_mis && m_cnt < CMAX) m_cnt++;
         // One injected beat per synchronized request; re-arm only once the request drops.
         if (m_pend) begin
            if (s_rv) begin m_pend = 0; m_spent = 1; end
         end else if (m_spent) begin
            if (!rfi) m_spent = 0;
         end else if (rfi) begin
            m_pend = 1;
         end
         m_mis = nmis;
         void'(en_h.pop_front()); en_h.push_back(s_en);
         void'(fi_h.pop_front()); fi_h.push_back(s_fi);
      end
   endtask

   task automatic beat(input bit valid, input bit bad);
      s_rv = valid;
      s_rd = {$urandom, $urandom};
      s_rp = odd64(s_rd) ^ bad;
      cyc();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, 0);
   endtask

   // Monitor: compares the DUT against the oldest pending expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge ACLK);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("waddr_parity", WADDR_PARITY, e.wa);
            chk("wdata_parity", WDATA_PARITY, e.wd);
            chk("raddr_parity", RADDR_PARITY, e.ra);
            chk("err", ERR_RDATA_PARITY, e.err);
            chk("err_b", ERR_RDATA_PARITY_B, !e.err);
`ifdef SIMPLE_TOP_PARITY_TX_ERRCNT_EN
            chk("err_cnt", ERR_CNT, e.cnt);
`endif
         end
      end
   end

   initial begin
      RESETN_ACLK = 1'b0;
      RDATA_VALID = 1'b0; ERR_CLR = 1'b0;
      ENERR_RDATA_PARITY = 1'b0; FIERR_RDATA_PARITY = 1'b0;
      model_clear();
      s_rst = 0; s_en = 0; s_fi = 0; s_clr = 0;
      idle(3);
      s_rst = 1;
      idle(2);

      // Directed generated-parity patterns.
      s_rand_bus = 0;
      s_wa = 32'h0000_0007; s_wd = 64'h1; s_ra = 32'h1;
      s_wav = 1; s_wdv = 1; s_rav = 1; idle(1);
      s_wav = 0; s_wdv = 0; s_rav = 0; idle(1);
      s_rand_bus = 1;

      // Enabled error: RDATA=3 with parity 1 mismatches, then a good beat keeps it sticky.
      s_en = 1; idle(3);
      s_rv = 1; s_rd = 64'h3; s_rp = 1; cyc();
      idle(3);
      beat(1, 0); idle(2);

      // Disabled error: count only, then clear.
      s_clr = 1; idle(1); s_clr = 0;
      s_en = 0; idle(3);
      repeat (3) beat(1, 1);
      idle(3);
      s_clr = 1; idle(1); s_clr = 0;
      idle(1);

      // Fault injection held long: exactly one corrupted beat, then a second request.
      s_en = 1; idle(3);
      s_fi = 1;
      for (int i = 0; i < 20; i++) beat(i % 4 == 3, 0);
      s_fi = 0; idle(5);
      s_fi = 1;
      for (int i = 0; i < 10; i++) beat(i % 3 == 2, 0);
      s_fi = 0; idle(4);

      // Clear coinciding with a registered mismatch.
      s_clr = 1; idle(1); s_clr = 0;
      beat(1, 1);
      s_clr = 1; idle(1); s_clr = 0;
      idle(2);

      // Saturation.
      repeat (300) beat(1, 1);
      idle(3);

      // Reset while ARMED with the error set.
      s_fi = 1; idle(5);
      s_rst = 0; idle(2);
      s_rst = 1; s_fi = 0; s_en = 1; idle(3);
      repeat (3) beat(1, 0);
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) s_en = ~s_en;
         if ($urandom_range(0, 19) == 0) s_fi = ~s_fi;
         s_clr = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 199) == 0) s_rst = 0;
         else                             s_rst = 1;
         beat($urandom_range(0, 1), $urandom_range(0, 5) == 0);
      end
      s_rst = 1; s_clr = 0;
      idle(3);

      @(negedge ACLK);
      @(negedge ACLK);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
